// File: rtl/nib_deser_if.sv
// ============================================================================
// Module   : nib_deser_if
// Brief    : Serial-link inputs and nibble/load/error outputs of nib_deser.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface nib_deser_if;
    logic       sclk;
    logic       sdi;
    logic       fs;
    logic       errclr;
    logic [3:0] dout;
    logic       ld;
    logic       ferr;

    modport master (
        output sclk, sdi, fs, errclr,
        input  dout, ld, ferr
    );

    modport slave (
        input  sclk, sdi, fs, errclr,
        output dout, ld, ferr
    );
endinterface

`default_nettype wire

// File: rtl/nib_deser.sv
// ============================================================================
// Module   : nib_deser
// Brief    : Frame-synced serial-to-nibble deserializer with load strobe and
//            sticky frame-error flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nib_deser #(
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         ck,
    input  logic         clr,
    nib_deser_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_fs_sync;
    logic                   r_sclk_prev;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [3:0] r_shreg;
    logic [3:0] r_dout;
    logic       r_ld;
    logic       r_ferr;
    logic       r_load_pend;

    logic       w_sclk_s;
    logic       w_sdi_s;
    logic       w_fs_s;
    logic       w_bit_ev;
    logic [3:0] w_shift_next;
    logic [3:0] w_first_bit;

    // SCLK/FS chains reset high so neither a false bit edge nor a stale frame
    // appears right after reset.
    always_ff @(posedge ck or posedge clr) begin
        if (clr) begin
            r_sclk_sync <= '1;
            r_sdi_sync  <= '0;
            r_fs_sync   <= '1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0],  bus.sdi};
            r_fs_sync   <= {r_fs_sync[SYNC_STAGES-2:0],   bus.fs};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdi_s  = r_sdi_sync[SYNC_STAGES-1];
    assign w_fs_s   = r_fs_sync[SYNC_STAGES-1];
    assign w_bit_ev = w_sclk_s & ~r_sclk_prev;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shreg[2:0], w_sdi_s};
            assign w_first_bit  = {3'b000, w_sdi_s};
        end else begin : g_lsb_first
            assign w_shift_next = {w_sdi_s, r_shreg[3:1]};
            assign w_first_bit  = {w_sdi_s, 3'b000};
        end
    endgenerate

    always_ff @(posedge ck or posedge clr) begin
        if (clr) begin
            r_state     <= ST_ARM;
            r_cnt       <= 3'd0;
            r_shreg     <= 4'd0;
            r_dout      <= 4'd0;
            r_ld        <= 1'b0;
            r_ferr      <= 1'b0;
            r_load_pend <= 1'b0;
        end else begin
            r_ld        <= 1'b0;
            r_load_pend <= 1'b0;

            // Nibble is published one cycle after the 4th bit is accepted.
            if (r_load_pend) begin
                r_dout <= r_shreg;
                r_ld   <= 1'b1;
            end

            // Error set below is a later assignment, so it wins over a clear.
            if (bus.errclr) begin
                r_ferr <= 1'b0;
            end

            case (r_state)
                ST_ARM: begin
                    if (!w_fs_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (w_fs_s) begin
                        r_state <= ST_SHIFT;
                        if (w_bit_ev) begin
                            r_shreg <= w_first_bit;
                            r_cnt   <= 3'd1;
                        end else begin
                            r_shreg <= 4'd0;
                            r_cnt   <= 3'd0;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (!w_fs_s) begin
                        if (r_cnt != 3'd0) begin
                            r_ferr <= 1'b1;
                        end
                        r_shreg <= 4'd0;
                        r_cnt   <= 3'd0;
                        r_state <= ST_IDLE;
                    end else if (w_bit_ev) begin
                        r_shreg <= w_shift_next;
                        if (r_cnt == 3'd3) begin
                            r_cnt       <= 3'd0;
                            r_load_pend <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (!w_fs_s) begin
                        r_state <= ST_IDLE;
                    end else if (w_bit_ev) begin
                        r_ferr <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

    assign bus.dout = r_dout;
    assign bus.ld   = r_ld;
    assign bus.ferr = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_nib_deser.sv
// ============================================================================
// Module   : tb_nib_deser
// Brief    : Directed bench for nib_deser, MSB-first and LSB-first instances.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nib_deser;

    logic ck = 1'b0;
    logic clr;
    logic sclk, sdi, fs, errclr;

    always #5 ck = ~ck;

    nib_deser_if bus_m ();
    nib_deser_if bus_l ();

    assign bus_m.sclk   = sclk;
    assign bus_m.sdi    = sdi;
    assign bus_m.fs     = fs;
    assign bus_m.errclr = errclr;
    assign bus_l.sclk   = sclk;
    assign bus_l.sdi    = sdi;
    assign bus_l.fs     = fs;
    assign bus_l.errclr = errclr;

    nib_deser #(.MSB_FIRST(1), .SYNC_STAGES(2)) u_msb (.ck(ck), .clr(clr), .bus(bus_m));
    nib_deser #(.MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (.ck(ck), .clr(clr), .bus(bus_l));

    int nvec  = 0;
    int nfail = 0;
    int ld_m  = 0;
    int ld_l  = 0;
    int wide  = 0;
    int stray = 0;
    logic [3:0] last_m = 4'd0, prev_m = 4'd0, last_l = 4'd0, prev_l = 4'd0;
    logic [3:0] dq_m, dq_l;
    logic       ldq_m = 1'b0, ldq_l = 1'b0;

    // Pre-edge snapshot: logs LD pulses, over-long LD, DOUT moving without LD.
    always @(posedge ck) begin
        if (bus_m.ld === 1'b1) begin
            ld_m++;
            prev_m = last_m;
            last_m = bus_m.dout;
        end
        if (bus_l.ld === 1'b1) begin
            ld_l++;
            prev_l = last_l;
            last_l = bus_l.dout;
        end
        if (bus_m.ld === 1'b1 && ldq_m === 1'b1) wide++;
        if (bus_l.ld === 1'b1 && ldq_l === 1'b1) wide++;
        if (clr === 1'b0 && bus_m.ld !== 1'b1 && bus_m.dout !== dq_m) stray++;
        if (clr === 1'b0 && bus_l.ld !== 1'b1 && bus_l.dout !== dq_l) stray++;
        ldq_m = bus_m.ld;
        ldq_l = bus_l.ld;
        dq_m  = bus_m.dout;
        dq_l  = bus_l.dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        sdi  = b;
        tick(5);
        sclk = 1'b1;
        tick(5);
    endtask

    // Sends v[n-1] first, down to v[0].
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic frame(input logic [7:0] v, input int n);
        fs = 1'b1;
        tick(4);
        send_bits(v, n);
        tick(2);
        fs = 1'b0;
        tick(6);
    endtask

    initial begin
        clr = 1'b1; sclk = 1'b0; sdi = 1'b0; fs = 1'b0; errclr = 1'b0;
        tick(3);
        chk("rst_dout", {28'd0, bus_m.dout}, 32'h0);
        chk("rst_ld",   {31'd0, bus_m.ld},   32'h0);
        chk("rst_ferr", {31'd0, bus_m.ferr}, 32'h0);
        clr = 1'b0;
        tick(5);

        // Basic frame 1,0,1,1
        frame(8'b1011, 4);
        chk("f1_ldcnt_m", ld_m, 1);
        chk("f1_ldval_m", {28'd0, last_m}, 32'hB);
        chk("f1_dout_m",  {28'd0, bus_m.dout}, 32'hB);
        chk("f1_ferr_m",  {31'd0, bus_m.ferr}, 32'h0);
        chk("f1_ldcnt_l", ld_l, 1);
        chk("f1_dout_l",  {28'd0, bus_l.dout}, 32'hD);

        // Short frame 1,1,1
        frame(8'b111, 3);
        chk("short_ferr_m",  {31'd0, bus_m.ferr}, 32'h1);
        chk("short_ferr_l",  {31'd0, bus_l.ferr}, 32'h1);
        chk("short_ldcnt_m", ld_m, 1);
        chk("short_dout_m",  {28'd0, bus_m.dout}, 32'hB);
        chk("short_dout_l",  {28'd0, bus_l.dout}, 32'hD);
        errclr = 1'b1;
        tick(1);
        errclr = 1'b0;
        chk("errclr_ferr_m", {31'd0, bus_m.ferr}, 32'h0);
        chk("errclr_ferr_l", {31'd0, bus_l.ferr}, 32'h0);

        // Long frame 0,1,0,1,1,1 with ERRCLR on the 6th bit event
        fs = 1'b1;
        tick(4);
        send_bits(8'b0101, 4);
        chk("long_ldcnt_m", ld_m, 2);
        chk("long_dout_m",  {28'd0, bus_m.dout}, 32'h5);
        chk("long_dout_l",  {28'd0, bus_l.dout}, 32'hA);
        chk("long_ferr4",   {31'd0, bus_m.ferr}, 32'h0);
        send_bit(1'b1);
        chk("long_ferr5",   {31'd0, bus_m.ferr}, 32'h1);
        sclk = 1'b0;
        sdi  = 1'b1;
        tick(5);
        sclk = 1'b1;
        tick(2);
        errclr = 1'b1;
        tick(1);
        errclr = 1'b0;
        tick(2);
        chk("long_ferr6_win", {31'd0, bus_m.ferr}, 32'h1);
        tick(2);
        fs = 1'b0;
        tick(6);
        chk("long_ldcnt_end", ld_m, 2);
        chk("long_dout_end",  {28'd0, bus_m.dout}, 32'h5);
        errclr = 1'b1;
        tick(1);
        errclr = 1'b0;

        // CLR mid-frame
        fs = 1'b1;
        tick(4);
        send_bits(8'b11, 2);
        clr = 1'b1;
        #1;
        chk("clr_async_dout", {28'd0, bus_m.dout}, 32'h0);
        tick(2);
        clr = 1'b0;
        send_bits(8'b01, 2);
        tick(4);
        chk("clr_ldcnt_m", ld_m, 2);
        chk("clr_ldcnt_l", ld_l, 2);
        chk("clr_dout_m",  {28'd0, bus_m.dout}, 32'h0);
        chk("clr_ferr_m",  {31'd0, bus_m.ferr}, 32'h0);
        fs = 1'b0;
        tick(6);
        frame(8'b0110, 4);
        chk("post_clr_ldcnt", ld_m, 3);
        chk("post_clr_val_m", {28'd0, last_m}, 32'h6);
        chk("post_clr_dout_l", {28'd0, bus_l.dout}, 32'h6);

        // Back-to-back frames with a one-cycle FS gap
        fs = 1'b1;
        tick(4);
        send_bits(8'b1010, 4);
        tick(5);
        fs = 1'b0;
        tick(1);
        fs = 1'b1;
        send_bits(8'b0101, 4);
        tick(5);
        fs = 1'b0;
        tick(6);
        chk("b2b_ldcnt_m", ld_m, 5);
        chk("b2b_first_m", {28'd0, prev_m}, 32'hA);
        chk("b2b_second_m", {28'd0, last_m}, 32'h5);
        chk("b2b_ldcnt_l", ld_l, 5);
        chk("b2b_first_l", {28'd0, prev_l}, 32'h5);
        chk("b2b_second_l", {28'd0, last_l}, 32'hA);
        chk("b2b_ferr_m",  {31'd0, bus_m.ferr}, 32'h0);

        chk("ld_single_cycle", wide, 0);
        chk("dout_only_with_ld", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
